// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle MIPS core: sequences fetch, decode, execute,
// memory and writeback over the shared datapath and tracks memory handshake timeouts.
module multicycle_controller #(
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       branch,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] pc_src,
    output logic [3:0] state,
    output logic       illegal,
    output logic       mem_timeout
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
        MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB  = 4'd7,
        BRANCH = 4'd8,  ADDIEX = 4'd9,  ADDIWB = 4'd10, JUMP   = 4'd11
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       mem_timeout_q, mem_timeout_d;

    logic       op_r, op_lw, op_sw, op_beq, op_addi, op_j;
    logic       funct_ok, decode_ok, waiting;
    logic [2:0] r_alu;
    logic       unused_zero;

    // The zero flag is consumed by the datapath PC-enable logic, not here.
    assign unused_zero = zero;

    assign op_r      = (opcode == 6'b000000);
    assign op_lw     = (opcode == 6'b100011);
    assign op_sw     = (opcode == 6'b101011);
    assign op_beq    = (opcode == 6'b000100);
    assign op_addi   = (opcode == 6'b001000);
    assign op_j      = (opcode == 6'b000010);
    assign decode_ok = op_lw | op_sw | (op_r & funct_ok) | op_beq | op_addi | op_j;

    always_comb begin
        r_alu    = 3'b010;
        funct_ok = 1'b1;
        case (funct)
            6'b100000: r_alu = 3'b010;
            6'b100010: r_alu = 3'b110;
            6'b100100: r_alu = 3'b000;
            6'b100101: r_alu = 3'b001;
            6'b101010: r_alu = 3'b111;
            default:   funct_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:  if (mem_ready) state_d = DECODE;
            DECODE: begin
                if (op_lw || op_sw)        state_d = MEMADR;
                else if (op_r && funct_ok) state_d = EXEC;
                else if (op_beq)           state_d = BRANCH;
                else if (op_addi)          state_d = ADDIEX;
                else if (op_j)             state_d = JUMP;
                else                       state_d = FETCH;
            end
            MEMADR: state_d = op_sw ? MEMWR : MEMRD;
            MEMRD:  if (mem_ready) state_d = MEMWB;
            MEMWR:  if (mem_ready) state_d = FETCH;
            EXEC:   state_d = ALUWB;
            ADDIEX: state_d = ADDIWB;
            default: state_d = FETCH;
        endcase
        if (reset) state_d = FETCH;
    end

    // The counter is zero outside a stalled memory state, so it is already clear on
    // entry to any wait state; it only climbs while a handshake is outstanding.
    assign waiting = ((state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR)) && !mem_ready;

    always_comb begin
        wait_cnt_d    = 8'd0;
        if (waiting)
            wait_cnt_d = (wait_cnt_q >= TIMEOUT_CNT) ? wait_cnt_q : wait_cnt_q + 8'd1;
        mem_timeout_d = mem_timeout_q | (wait_cnt_d == TIMEOUT_CNT);
        if (reset) begin
            wait_cnt_d    = 8'd0;
            mem_timeout_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        state_q       <= state_d;
        wait_cnt_q    <= wait_cnt_d;
        mem_timeout_q <= mem_timeout_d;
    end

    always_comb begin
        pc_write    = 1'b0;
        branch      = 1'b0;
        iord        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_control = 3'b010;
        pc_src      = 2'b00;
        illegal     = 1'b0;
        case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                illegal   = !decode_ok;
            end
            MEMADR, ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
            end
            MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            EXEC: begin
                alu_src_a   = 1'b1;
                alu_control = r_alu;
            end
            ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = 3'b110;
                pc_src      = 2'b01;
                branch      = 1'b1;
            end
            ADDIWB: reg_write = 1'b1;
            JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: ;
        endcase
        // Write strobes must stay quiet while reset is held, whatever state is showing.
        if (reset) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            branch    = 1'b0;
            reg_write = 1'b0;
            mem_write = 1'b0;
            mem_read  = 1'b0;
            illegal   = 1'b0;
        end
    end

    assign state       = state_q;
    assign mem_timeout = mem_timeout_q;

endmodule
